// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the 5-stage pipeline sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned PC_SEL_W  = 2;
  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [PC_SEL_W-1:0] {
    PC_SEL_SEQ   = PC_SEL_W'(0),
    PC_SEL_BJU   = PC_SEL_W'(1),
    PC_SEL_TRAP  = PC_SEL_W'(2),
    PC_SEL_FENCE = PC_SEL_W'(3)
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_TRAP_WAIT   = 2'd1,
    ST_FENCE_DRAIN = 2'd2,
    ST_FENCE_WAIT  = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic pc_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
  } pipe_en_t;

  localparam pipe_en_t EN_NONE    = pipe_en_t'(4'b0000);
  localparam pipe_en_t EN_ALL     = pipe_en_t'(4'b1111);
  // IF/ID held, bubble into EX, downstream keeps moving
  localparam pipe_en_t EN_HOLD_IF = pipe_en_t'(4'b0111);

endpackage

// File: rtl/pipe_stage_ctrl_if.sv
// Hazard/redirect inputs and stage-control outputs of the pipeline sequencer.
interface pipe_stage_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic                if_id_stall;
  logic                ifu_inst_valid;
  logic                lsu_busy;
  logic                id_bju_redirect;
  logic                id_fence_i;
  logic                wb_trap;
  logic                icache_inv_done;
  logic                pc_en;
  logic                id_ex_en;
  logic                ex_mem_en;
  logic                mem_wb_en;
  logic                id_valid;
  logic                ex_valid;
  logic                mem_valid;
  logic                wb_valid;
  logic [PC_SEL_W-1:0] pc_sel;
  logic                icache_inv;
  logic [1:0]          ctrl_state;

  modport master (
    input  if_id_stall, ifu_inst_valid, lsu_busy, id_bju_redirect, id_fence_i,
           wb_trap, icache_inv_done,
    output pc_en, id_ex_en, ex_mem_en, mem_wb_en, id_valid, ex_valid, mem_valid,
           wb_valid, pc_sel, icache_inv, ctrl_state
  );

  modport slave (
    output if_id_stall, ifu_inst_valid, lsu_busy, id_bju_redirect, id_fence_i,
           wb_trap, icache_inv_done,
    input  pc_en, id_ex_en, ex_mem_en, mem_wb_en, id_valid, ex_valid, mem_valid,
           wb_valid, pc_sel, icache_inv, ctrl_state
  );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with enable and synchronous clear.
module pipe_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_ctrl.sv
// IF/ID/EX/MEM/WB sequencer: stage valids, register enables, redirects, fence.i drain.
// Optional perf counters when PIPE_CTRL_PERF_EN is defined.
module pipe_stage_ctrl
  import pipe_ctrl_pkg::*;
`ifdef PIPE_CTRL_PERF_EN
#(
  parameter int unsigned CNT_W = CNT_W_DEF
)
`endif
(
  input  logic              clk,
  input  logic              rst,
  pipe_stage_ctrl_if.master ctl
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_bubble_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

  ctrl_state_e state_q, state_d;
  logic        id_valid_q, id_valid_d, ex_valid_q, ex_valid_d;
  logic        mem_valid_q, mem_valid_d, wb_valid_q, wb_valid_d;
  pipe_en_t    en_c;
  pc_sel_e     pc_sel_c;
  logic        icache_inv_c, take_trap_c;

  always_comb begin
    state_d      = state_q;
    id_valid_d   = id_valid_q;
    ex_valid_d   = ex_valid_q;
    mem_valid_d  = mem_valid_q;
    wb_valid_d   = wb_valid_q;
    en_c         = EN_NONE;
    pc_sel_c     = PC_SEL_SEQ;
    icache_inv_c = 1'b0;
    take_trap_c  = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          if (ctl.wb_trap && wb_valid_q) begin
            if (ctl.lsu_busy) state_d = ST_TRAP_WAIT;
            else              take_trap_c = 1'b1;
          end else if (ctl.lsu_busy) begin
            en_c = EN_NONE;
          end else if (ctl.id_fence_i && id_valid_q) begin
            state_d     = ST_FENCE_DRAIN;
            en_c        = EN_HOLD_IF;
            ex_valid_d  = 1'b0;
            mem_valid_d = ex_valid_q;
            wb_valid_d  = mem_valid_q;
          end else if (ctl.if_id_stall && id_valid_q) begin
            en_c        = EN_HOLD_IF;
            ex_valid_d  = 1'b0;
            mem_valid_d = ex_valid_q;
            wb_valid_d  = mem_valid_q;
          end else if (ctl.id_bju_redirect && id_valid_q) begin
            // branch moves on to EX; the wrong-path fetch in IF is dropped
            pc_sel_c    = PC_SEL_BJU;
            en_c        = EN_ALL;
            id_valid_d  = 1'b0;
            ex_valid_d  = id_valid_q;
            mem_valid_d = ex_valid_q;
            wb_valid_d  = mem_valid_q;
          end else begin
            en_c        = EN_ALL;
            en_c.pc_en  = ctl.ifu_inst_valid;
            id_valid_d  = ctl.ifu_inst_valid;
            ex_valid_d  = id_valid_q;
            mem_valid_d = ex_valid_q;
            wb_valid_d  = mem_valid_q;
          end
        end
        ST_TRAP_WAIT: begin
          if (!ctl.lsu_busy) take_trap_c = 1'b1;
        end
        ST_FENCE_DRAIN: begin
          if (ctl.lsu_busy) begin
            en_c = EN_NONE;
          end else if (!ex_valid_q && !mem_valid_q && !wb_valid_q) begin
            icache_inv_c = 1'b1;
            state_d      = ST_FENCE_WAIT;
          end else begin
            en_c        = EN_HOLD_IF;
            ex_valid_d  = 1'b0;
            mem_valid_d = ex_valid_q;
            wb_valid_d  = mem_valid_q;
          end
        end
        ST_FENCE_WAIT: begin
          // fence itself proceeds to EX; fetch restarts at fence pc+4
          if (ctl.icache_inv_done) begin
            pc_sel_c    = PC_SEL_FENCE;
            en_c        = EN_ALL;
            id_valid_d  = 1'b0;
            ex_valid_d  = 1'b1;
            mem_valid_d = ex_valid_q;
            wb_valid_d  = mem_valid_q;
            state_d     = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
      if (take_trap_c) begin
        pc_sel_c    = PC_SEL_TRAP;
        en_c        = EN_ALL;
        id_valid_d  = 1'b0;
        ex_valid_d  = 1'b0;
        mem_valid_d = 1'b0;
        wb_valid_d  = 1'b0;
        state_d     = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      id_valid_q  <= 1'b0;
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_valid_q  <= id_valid_d;
      ex_valid_q  <= ex_valid_d;
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
    end
  end

  assign ctl.pc_en      = en_c.pc_en;
  assign ctl.id_ex_en   = en_c.id_ex_en;
  assign ctl.ex_mem_en  = en_c.ex_mem_en;
  assign ctl.mem_wb_en  = en_c.mem_wb_en;
  assign ctl.id_valid   = id_valid_q;
  assign ctl.ex_valid   = ex_valid_q;
  assign ctl.mem_valid  = mem_valid_q;
  assign ctl.wb_valid   = wb_valid_q;
  assign ctl.pc_sel     = pc_sel_c;
  assign ctl.icache_inv = icache_inv_c;
  assign ctl.ctrl_state = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic stall_inc_c, bubble_inc_c, flush_inc_c;

  assign stall_inc_c  = ctl.if_id_stall || ctl.lsu_busy;
  // EX register clocked with an empty slot, excluding the trap flush itself
  assign bubble_inc_c = en_c.id_ex_en && !ex_valid_d && (pc_sel_c != PC_SEL_TRAP);
  assign flush_inc_c  = (pc_sel_c == PC_SEL_BJU) || (pc_sel_c == PC_SEL_TRAP);

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(stall_inc_c), .cnt(perf_stall_cnt)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .inc(bubble_inc_c), .cnt(perf_bubble_cnt)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(flush_inc_c), .cnt(perf_flush_cnt)
  );
`endif

endmodule
